// File: rtl/int_decl_gen.sv
`default_nettype none
// ============================================================================
//  Module      : int_decl_gen
//  Description : Streams one C-style declaration "int id0,id1,...;" one
//                character per output handshake. Identifier characters are
//                passed through from the input stream with a one-cycle
//                register stage. Identifier syntax errors and use of the
//                keyword "int" as an identifier raise a sticky err flag.
//  Options     : INTGEN_COMMA_SPACE_EN - when defined, a space is emitted
//                after every comma separating identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_decl_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    input  logic       in_end,
    input  logic       in_final,
    output logic       in_ready,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

`ifdef INTGEN_COMMA_SPACE_EN
    localparam logic c_COMMA_SPACE = 1'b1;
`else
    localparam logic c_COMMA_SPACE = 1'b0;
`endif

    localparam logic [7:0] c_CH_I     = 8'h69;  // 'i'
    localparam logic [7:0] c_CH_N     = 8'h6E;  // 'n'
    localparam logic [7:0] c_CH_T     = 8'h74;  // 't'
    localparam logic [7:0] c_CH_SP    = 8'h20;  // ' '
    localparam logic [7:0] c_CH_COMMA = 8'h2C;  // ','
    localparam logic [7:0] c_CH_SEMI  = 8'h3B;  // ';'
    localparam logic [7:0] c_CH_UNDER = 8'h5F;  // '_'

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        KW_I     = 4'd1,
        KW_N     = 4'd2,
        KW_T     = 4'd3,
        SP       = 4'd4,
        ID_FIRST = 4'd5,
        ID_REST  = 4'd6,
        COMMA    = 4'd7,
        CSP      = 4'd8,
        SEMI     = 4'd9,
        FIN      = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_out_char;
    logic        r_out_valid;
    logic        r_err;
    logic        r_semi_sent;
    logic [1:0]  r_kw_cnt;
    logic        r_kw_match;

    logic        w_out_free;
    logic        w_in_ready;
    logic        w_in_xfer;
    logic        w_load;
    logic [7:0]  w_load_char;
    logic        w_semi_set;
    logic        w_first;
    logic        w_char_ok;
    logic [1:0]  w_kw_pos;
    logic        w_kw_prefix;
    logic [7:0]  w_kw_exp;
    logic        w_kw_still;
    logic        w_kw_hit;

    function automatic logic f_is_alpha(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
    endfunction

    function automatic logic f_is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // The output register can take a new character when empty or draining.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = ((r_state == ID_FIRST) || (r_state == ID_REST)) && w_out_free;
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_first    = (r_state == ID_FIRST);

    // Character class check: digits are only legal after the first position.
    assign w_char_ok = f_is_alpha(in_char) || (in_char == c_CH_UNDER) ||
                       (!w_first && f_is_digit(in_char));

    // Keyword tracker: r_kw_cnt is how many leading chars matched "int" so far,
    // r_kw_match says the identifier is still a prefix of "int".
    assign w_kw_pos    = w_first ? 2'd0 : r_kw_cnt;
    assign w_kw_prefix = w_first ? 1'b1 : r_kw_match;

    // Expected keyword character at the current identifier position.
    always_comb begin
        w_kw_exp = 8'h00;
        case (w_kw_pos)
            2'd0:    w_kw_exp = c_CH_I;
            2'd1:    w_kw_exp = c_CH_N;
            2'd2:    w_kw_exp = c_CH_T;
            default: w_kw_exp = 8'h00;
        endcase
    end

    assign w_kw_still = w_kw_prefix && (w_kw_pos != 2'd3) && (in_char == w_kw_exp);
    assign w_kw_hit   = w_kw_still && (w_kw_pos == 2'd2);

    // Next-state and output-register load selection.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_char  = 8'h00;
        w_semi_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = KW_I;
                end
            end
            KW_I: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_char  = c_CH_I;
                    w_state_next = KW_N;
                end
            end
            KW_N: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_char  = c_CH_N;
                    w_state_next = KW_T;
                end
            end
            KW_T: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_char  = c_CH_T;
                    w_state_next = SP;
                end
            end
            SP: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_char  = c_CH_SP;
                    w_state_next = ID_FIRST;
                end
            end
            ID_FIRST, ID_REST: begin
                if (w_in_xfer) begin
                    w_load      = 1'b1;
                    w_load_char = in_char;
                    if (in_end) begin
                        w_state_next = in_final ? SEMI : COMMA;
                    end else begin
                        w_state_next = ID_REST;
                    end
                end
            end
            COMMA: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_char  = c_CH_COMMA;
                    w_state_next = c_COMMA_SPACE ? CSP : ID_FIRST;
                end
            end
            CSP: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_char  = c_CH_SP;
                    w_state_next = ID_FIRST;
                end
            end
            SEMI: begin
                // Load ';' once, then wait for that very character to leave.
                if (!r_semi_sent) begin
                    if (w_out_free) begin
                        w_load      = 1'b1;
                        w_load_char = c_CH_SEMI;
                        w_semi_set  = 1'b1;
                    end
                end else if (r_out_valid && out_ready) begin
                    w_state_next = FIN;
                end
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output character register: load wins, otherwise drain on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_char  <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_char  <= w_load_char;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Remembers that ';' has been queued while sitting in SEMI.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_semi_sent <= 1'b0;
        end else begin
            r_semi_sent <= (r_state == SEMI) && (r_semi_sent || w_semi_set);
        end
    end

    // Keyword match tracking, advanced on every accepted identifier char.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kw_cnt   <= 2'd0;
            r_kw_match <= 1'b0;
        end else if (w_in_xfer) begin
            r_kw_cnt   <= w_kw_still ? (w_kw_pos + 2'd1) : w_kw_pos;
            r_kw_match <= w_kw_still;
        end
    end

    // Sticky error flag, cleared when a new declaration starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_in_xfer && (!w_char_ok || (in_end && w_kw_hit))) begin
            r_err <= 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_char  = r_out_char;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIN);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_int_decl_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_decl_gen
//  Description : Self-checking bench for int_decl_gen. Directed and random
//                declarations are compared against a string-level model of
//                the expected character stream and error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_decl_gen;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic [7:0] in_char   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       in_end    = 1'b0;
    logic       in_final  = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic [7:0] out_char;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int phase = 0;
    int done_cnt = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    logic [7:0] id_buf[0:7][0:7];
    int         id_len[0:7];
    int         n_ids = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_char  = 8'h00;

    int_decl_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_char   (in_char),
        .in_valid  (in_valid),
        .in_end    (in_end),
        .in_final  (in_final),
        .in_ready  (in_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready pattern: 0 always, 1 coin flip, 2 the 1,0,0,1 cycle, 3 rarely ready.
    always @(posedge clk) begin
        #1;
        case (mode)
            1:       out_ready = ($urandom_range(0, 1) == 1);
            2:       begin out_ready = ((phase % 4) == 0) || ((phase % 4) == 3); phase++; end
            3:       out_ready = ($urandom_range(0, 7) == 0);
            default: out_ready = 1'b1;
        endcase
    end

    // Output monitor: records transfers, checks stall stability and done pulses.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_char", out_char, prev_char);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) got_q.push_back(out_char);
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_char  = out_char;
        end
    end

    task automatic set_id(input int k, input string s);
        id_len[k] = s.len();
        for (int j = 0; j < s.len(); j++) id_buf[k][j] = s[j];
    endtask

    function automatic bit legal(input logic [7:0] c, input bit first);
        bit alpha;
        alpha = (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A) || (c == 8'h5F);
        return alpha || (!first && c >= 8'h30 && c <= 8'h39);
    endfunction

    function automatic bit is_int(input int k);
        return (id_len[k] == 3) && (id_buf[k][0] == 8'h69) &&
               (id_buf[k][1] == 8'h6E) && (id_buf[k][2] == 8'h74);
    endfunction

    task automatic send_char(input logic [7:0] c, input bit last, input bit fin);
        int t;
        in_char  = c;
        in_valid = 1'b1;
        in_end   = last;
        in_final = fin;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("in_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_end   = 1'b0;
        in_final = 1'b0;
    endtask

    task automatic run_decl(input bit hold_start);
        logic       err_exp;
        logic [7:0] c;
        bit         last;
        bit         fin;
        int         t;
        int         first_bad;

        exp_q.delete();
        exp_q.push_back(8'h69); exp_q.push_back(8'h6E);
        exp_q.push_back(8'h74); exp_q.push_back(8'h20);
        for (int k = 0; k < n_ids; k++) begin
            if (k > 0) begin
                exp_q.push_back(8'h2C);
`ifdef INTGEN_COMMA_SPACE_EN
                exp_q.push_back(8'h20);
`endif
            end
            for (int j = 0; j < id_len[k]; j++) exp_q.push_back(id_buf[k][j]);
        end
        exp_q.push_back(8'h3B);

        got_q.delete();
        done_cnt = 0;
        err_exp  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        chk("busy_on_start", busy, 1);
        chk("err_cleared", err, 0);

        for (int k = 0; k < n_ids; k++) begin
            for (int j = 0; j < id_len[k]; j++) begin
                c    = id_buf[k][j];
                last = (j == id_len[k] - 1);
                fin  = last && (k == n_ids - 1);
                if ($urandom_range(0, 3) == 0) begin
                    in_end   = 1'b1;
                    in_final = ($urandom_range(0, 1) == 1);
                    @(posedge clk); #1;
                    in_end   = 1'b0;
                    in_final = 1'b0;
                end
                send_char(c, last, fin);
                if (!legal(c, j == 0)) err_exp = 1'b1;
                if (last && is_int(k)) err_exp = 1'b1;
                chk("err_track", err, err_exp);
            end
        end
        start = 1'b0;

        t = 0;
        while (done !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("done_once", done_cnt, 1);
        chk("idle_after", busy, 0);
        chk("err_final", err, err_exp);
        chk("stream_len", got_q.size(), exp_q.size());
        first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (first_bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) first_bad = i;
        end
        chk("stream_first_bad_idx", first_bad, 32'hFFFF_FFFF);
    endtask

    initial begin
        int    t;
        string good;
        string poor;
        good = "abqzAMZ_0159int";
        poor = "-$ .9";

        // Reset values.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single identifier.
        mode = 0;
        n_ids = 1; set_id(0, "a");
        run_decl(1'b0);

        // Two identifiers with separator.
        n_ids = 2; set_id(0, "x1"); set_id(1, "_y");
        run_decl(1'b0);

        // Stalling downstream with the 1,0,0,1 pattern.
        mode = 2; phase = 0;
        n_ids = 1; set_id(0, "ab");
        run_decl(1'b0);
        mode = 0;

        // Illegal leading digit and keyword as identifier.
        n_ids = 1; set_id(0, "9a");
        run_decl(1'b0);
        n_ids = 1; set_id(0, "int");
        run_decl(1'b0);

        // start held high while busy must not disturb the stream.
        n_ids = 2; set_id(0, "q"); set_id(1, "r");
        run_decl(1'b1);

        // Reset in the middle of the keyword.
        got_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (got_q.size() < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mid_two_chars", got_q.size(), 2);
        chk("mid_char0", got_q[0], 8'h69);
        chk("mid_char1", got_q[1], 8'h6E);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        n_ids = 1; set_id(0, "ok");
        run_decl(1'b0);

        // Random declarations under random downstream behaviour.
        for (int r = 0; r < 12; r++) begin
            mode  = $urandom_range(1, 3);
            n_ids = $urandom_range(1, 4);
            for (int k = 0; k < n_ids; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    set_id(k, "int");
                end else begin
                    id_len[k] = $urandom_range(1, 6);
                    for (int j = 0; j < id_len[k]; j++) begin
                        if ($urandom_range(0, 9) == 0)
                            id_buf[k][j] = poor[$urandom_range(0, poor.len() - 1)];
                        else
                            id_buf[k][j] = good[$urandom_range(0, good.len() - 1)];
                    end
                end
            end
            run_decl($urandom_range(0, 1) == 1);
        end
        mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
